// File: rtl/vga_frame_timing.sv
// 640x480@60 VGA frame timing: pixel-clock divider feeding horizontal/vertical phase FSMs.
// Sync and video_on are registered from next-state phases; the strobes are decoded from registers.
module vga_frame_timing #(
   parameter int DIV      = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic       pix_tick,
   output logic [9:0] hcount,
   output logic [9:0] vcount,
   output logic [1:0] hphase,
   output logic [1:0] vphase,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       line_end,
   output logic       frame_end
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   // Last column/line of each phase; the phase FSM leaves a phase on these values.
   localparam logic [9:0] H_END_A = 10'(H_ACTIVE - 1);
   localparam logic [9:0] H_END_F = 10'(H_ACTIVE + H_FRONT - 1);
   localparam logic [9:0] H_END_S = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] H_END_B = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_END_A = 10'(V_ACTIVE - 1);
   localparam logic [9:0] V_END_F = 10'(V_ACTIVE + V_FRONT - 1);
   localparam logic [9:0] V_END_S = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
   localparam logic [9:0] V_END_B = 10'(V_TOTAL - 1);

   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FRONT  = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BACK   = 2'd3
   } phase_e;

   logic [DW-1:0] div_q, div_d;
   logic [9:0]    hcount_q, hcount_d, vcount_q, vcount_d;
   phase_e        hphase_q, hphase_d, vphase_q, vphase_d;
   logic          hsync_q, vsync_q, video_on_q;

   function automatic phase_e next_phase(input phase_e ph, input logic [9:0] cnt,
                                         input logic [9:0] e_a, input logic [9:0] e_f,
                                         input logic [9:0] e_s, input logic [9:0] e_b);
      next_phase = ph;
      case (ph)
         PH_ACTIVE: if (cnt == e_a) next_phase = PH_FRONT;
         PH_FRONT:  if (cnt == e_f) next_phase = PH_SYNC;
         PH_SYNC:   if (cnt == e_s) next_phase = PH_BACK;
         PH_BACK:   if (cnt == e_b) next_phase = PH_ACTIVE;
      endcase
   endfunction

   assign pix_tick  = en & (div_q == DIV_LAST);
   assign line_end  = pix_tick & (hcount_q == H_END_B);
   assign frame_end = line_end & (vcount_q == V_END_B);

   always_comb begin
      div_d    = div_q;
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      hphase_d = hphase_q;
      vphase_d = vphase_q;
      if (en) begin
         div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
      end
      if (pix_tick) begin
         hcount_d = (hcount_q == H_END_B) ? '0 : hcount_q + 10'd1;
         hphase_d = next_phase(hphase_q, hcount_q, H_END_A, H_END_F, H_END_S, H_END_B);
      end
      // Vertical state moves only at the end of a line, so both wrap together on frame_end.
      if (line_end) begin
         vcount_d = (vcount_q == V_END_B) ? '0 : vcount_q + 10'd1;
         vphase_d = next_phase(vphase_q, vcount_q, V_END_A, V_END_F, V_END_S, V_END_B);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q      <= '0;
         hcount_q   <= '0;
         vcount_q   <= '0;
         hphase_q   <= PH_ACTIVE;
         vphase_q   <= PH_ACTIVE;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
         video_on_q <= 1'b1;
      end else begin
         div_q      <= div_d;
         hcount_q   <= hcount_d;
         vcount_q   <= vcount_d;
         hphase_q   <= hphase_d;
         vphase_q   <= vphase_d;
         hsync_q    <= (hphase_d != PH_SYNC);
         vsync_q    <= (vphase_d != PH_SYNC);
         video_on_q <= (hphase_d == PH_ACTIVE) && (vphase_d == PH_ACTIVE);
      end
   end

   assign hcount   = hcount_q;
   assign vcount   = vcount_q;
   assign hphase   = hphase_q;
   assign vphase   = vphase_q;
   assign hsync    = hsync_q;
   assign vsync    = vsync_q;
   assign video_on = video_on_q;

endmodule

// File: tb/tb_vga_frame_timing.sv
// Directed bench for vga_frame_timing: default timing at DIV=2, a DIV=1 instance,
// and a shrunken-geometry instance so full frames fit in a short run.
`define CHK(tag, obs, exp) \
   begin \
      n_assert++; \
      assert ((obs) === (exp)) else begin \
         n_fail++; \
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp); \
      end \
   end

module tb_vga_frame_timing;

   logic clk = 1'b0;
   logic rst;
   logic en;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int k        = 0;

   logic       pix_tick, hsync, vsync, video_on, line_end, frame_end;
   logic [9:0] hcount, vcount;
   logic [1:0] hphase, vphase;

   logic       d1_pix_tick, d1_hsync, d1_vsync, d1_video_on, d1_line_end, d1_frame_end;
   logic [9:0] d1_hcount, d1_vcount;
   logic [1:0] d1_hphase, d1_vphase;

   logic       sm_pix_tick, sm_hsync, sm_vsync, sm_video_on, sm_line_end, sm_frame_end;
   logic [9:0] sm_hcount, sm_vcount;
   logic [1:0] sm_hphase, sm_vphase;

   vga_frame_timing u_dut (
      .clk(clk), .rst(rst), .en(en), .pix_tick(pix_tick), .hcount(hcount), .vcount(vcount),
      .hphase(hphase), .vphase(vphase), .hsync(hsync), .vsync(vsync), .video_on(video_on),
      .line_end(line_end), .frame_end(frame_end)
   );

   vga_frame_timing #(.DIV(1)) u_d1 (
      .clk(clk), .rst(rst), .en(en), .pix_tick(d1_pix_tick), .hcount(d1_hcount),
      .vcount(d1_vcount), .hphase(d1_hphase), .vphase(d1_vphase), .hsync(d1_hsync),
      .vsync(d1_vsync), .video_on(d1_video_on), .line_end(d1_line_end),
      .frame_end(d1_frame_end)
   );

   // 15 columns (8/2/3/2) by 10 lines (6/1/2/1): frame period 300 clk at DIV=2.
   vga_frame_timing #(.DIV(2), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                      .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) u_sm (
      .clk(clk), .rst(rst), .en(en), .pix_tick(sm_pix_tick), .hcount(sm_hcount),
      .vcount(sm_vcount), .hphase(sm_hphase), .vphase(sm_vphase), .hsync(sm_hsync),
      .vsync(sm_vsync), .video_on(sm_video_on), .line_end(sm_line_end),
      .frame_end(sm_frame_end)
   );

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic adv(input int target);
      step(target - k);
      k = target;
   endtask

   initial begin
      int hs_low, act, le_cnt, bad, fe_cnt, fe_first, fe_second, vs_low, sm_hs_low, sm_le;

      rst = 1'b1;
      en  = 1'b0;
      step(3);
      `CHK("rst_hcount", hcount, 10'd0)
      `CHK("rst_vcount", vcount, 10'd0)
      `CHK("rst_hphase", hphase, 2'd0)
      `CHK("rst_vphase", vphase, 2'd0)
      `CHK("rst_hsync", hsync, 1'b1)
      `CHK("rst_vsync", vsync, 1'b1)
      `CHK("rst_video_on", video_on, 1'b1)
      `CHK("rst_pix_tick", pix_tick, 1'b0)
      `CHK("rst_line_end", line_end, 1'b0)
      `CHK("rst_frame_end", frame_end, 1'b0)

      // k counts rising edges since release with en=1; samples taken at the falling edge.
      rst = 1'b0;
      en  = 1'b1;
      #1;
      `CHK("k0_pix_tick", pix_tick, 1'b0)
      `CHK("k0_d1_pix_tick", d1_pix_tick, 1'b1)
      step(1); k = 1;
      `CHK("k1_pix_tick", pix_tick, 1'b1)
      `CHK("k1_hcount", hcount, 10'd0)
      `CHK("k1_d1_pix_tick", d1_pix_tick, 1'b1)
      adv(2);
      `CHK("k2_hcount", hcount, 10'd1)
      `CHK("k2_pix_tick", pix_tick, 1'b0)
      `CHK("k2_d1_hcount", d1_hcount, 10'd2)
      `CHK("k2_d1_pix_tick", d1_pix_tick, 1'b1)

      adv(1279);
      `CHK("h639_hcount", hcount, 10'd639)
      `CHK("h639_pix_tick", pix_tick, 1'b1)
      `CHK("h639_video_on", video_on, 1'b1)
      `CHK("h639_hphase", hphase, 2'd0)
      adv(1280);
      `CHK("h640_hcount", hcount, 10'd640)
      `CHK("h640_video_on", video_on, 1'b0)
      `CHK("h640_hphase", hphase, 2'd1)
      `CHK("h640_hsync", hsync, 1'b1)
      adv(1311);
      `CHK("h655_hsync", hsync, 1'b1)
      adv(1312);
      `CHK("h656_hcount", hcount, 10'd656)
      `CHK("h656_hphase", hphase, 2'd2)
      `CHK("h656_hsync", hsync, 1'b0)
      adv(1503);
      `CHK("h751_hsync", hsync, 1'b0)
      adv(1504);
      `CHK("h752_hphase", hphase, 2'd3)
      `CHK("h752_hsync", hsync, 1'b1)
      adv(1599);
      `CHK("h799_hcount", hcount, 10'd799)
      `CHK("h799_line_end", line_end, 1'b1)
      `CHK("h799_frame_end", frame_end, 1'b0)
      `CHK("h799_vcount", vcount, 10'd0)
      adv(1600);
      `CHK("wrap_hcount", hcount, 10'd0)
      `CHK("wrap_vcount", vcount, 10'd1)
      `CHK("wrap_line_end", line_end, 1'b0)
      `CHK("wrap_video_on", video_on, 1'b1)
      `CHK("wrap_hphase", hphase, 2'd0)

      hs_low = 0; act = 0; le_cnt = 0;
      for (int i = 0; i < 1600; i++) begin
         if (pix_tick && !hsync) hs_low++;
         if (pix_tick && video_on) act++;
         if (line_end) le_cnt++;
         step(1);
      end
      k = 3200;
      `CHK("line1_hsync_low_ticks", hs_low, 96)
      `CHK("line1_active_ticks", act, 640)
      `CHK("line1_line_end_count", le_cnt, 1)
      `CHK("line2_vcount", vcount, 10'd2)

      adv(3401);
      `CHK("hold_pre_hcount", hcount, 10'd100)
      `CHK("hold_pre_pix_tick", pix_tick, 1'b1)
      en = 1'b0;
      #1;
      `CHK("hold_pix_tick_suppressed", pix_tick, 1'b0)
      `CHK("hold_d1_pix_tick", d1_pix_tick, 1'b0)
      bad = 0;
      for (int i = 0; i < 37; i++) begin
         step(1);
         if (hcount !== 10'd100 || vcount !== 10'd2 || pix_tick !== 1'b0 ||
             line_end !== 1'b0 || video_on !== 1'b1 || hsync !== 1'b1) bad++;
      end
      `CHK("hold_frozen_cycles_bad", bad, 0)
      en = 1'b1;
      #1;
      `CHK("resume_pix_tick", pix_tick, 1'b1)
      `CHK("resume_hcount", hcount, 10'd100)
      step(1);
      `CHK("resume_next_hcount", hcount, 10'd101)
      `CHK("resume_next_pix_tick", pix_tick, 1'b0)

      step(1198);
      `CHK("prerst_hcount", hcount, 10'd700)
      `CHK("prerst_vcount", vcount, 10'd2)
      `CHK("prerst_hsync", hsync, 1'b0)
      `CHK("prerst_video_on", video_on, 1'b0)
      #2 rst = 1'b1;
      #1;
      `CHK("async_rst_hcount", hcount, 10'd0)
      `CHK("async_rst_vcount", vcount, 10'd0)
      `CHK("async_rst_hsync", hsync, 1'b1)
      `CHK("async_rst_vsync", vsync, 1'b1)
      `CHK("async_rst_video_on", video_on, 1'b1)
      `CHK("async_rst_hphase", hphase, 2'd0)
      `CHK("async_rst_pix_tick", pix_tick, 1'b0)
      `CHK("async_rst_line_end", line_end, 1'b0)
      step(1);
      rst = 1'b0;

      fe_cnt = 0; fe_first = -1; fe_second = -1; vs_low = 0; sm_hs_low = 0; sm_le = 0;
      for (int i = 0; i < 700; i++) begin
         if (i == 0) `CHK("rel_k0_pix_tick", pix_tick, 1'b0)
         if (i == 1) `CHK("rel_k1_pix_tick", pix_tick, 1'b1)
         if (i == 2) `CHK("rel_k2_hcount", hcount, 10'd1)
         if (i == 208) `CHK("sm_line6_vsync", sm_vsync, 1'b1)
         if (i == 210) begin
            `CHK("sm_line7_vcount", sm_vcount, 10'd7)
            `CHK("sm_line7_vsync", sm_vsync, 1'b0)
            `CHK("sm_line7_vphase", sm_vphase, 2'd2)
         end
         if (i == 299) begin
            `CHK("sm_last_video_on", sm_video_on, 1'b0)
            `CHK("sm_last_hphase", sm_hphase, 2'd3)
            `CHK("sm_last_vphase", sm_vphase, 2'd3)
         end
         if (i == 300) begin
            `CHK("sm_fwrap_hcount", sm_hcount, 10'd0)
            `CHK("sm_fwrap_vcount", sm_vcount, 10'd0)
            `CHK("sm_fwrap_hphase", sm_hphase, 2'd0)
            `CHK("sm_fwrap_vphase", sm_vphase, 2'd0)
            `CHK("sm_fwrap_video_on", sm_video_on, 1'b1)
         end
         if (sm_frame_end) begin
            `CHK("sm_fe_hcount", sm_hcount, 10'd14)
            `CHK("sm_fe_vcount", sm_vcount, 10'd9)
            fe_cnt++;
            if (fe_first < 0) fe_first = i;
            else if (fe_second < 0) fe_second = i;
         end
         if (sm_pix_tick && !sm_vsync) vs_low++;
         if (sm_pix_tick && !sm_hsync) sm_hs_low++;
         if (sm_line_end) sm_le++;
         step(1);
      end
      `CHK("sm_frame_end_count", fe_cnt, 2)
      `CHK("sm_first_frame_end", fe_first, 299)
      `CHK("sm_frame_period", fe_second - fe_first, 300)
      `CHK("sm_vsync_low_ticks", vs_low, 60)
      `CHK("sm_hsync_low_ticks", sm_hs_low, 69)
      `CHK("sm_line_end_count", sm_le, 23)

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
